// File: rtl/sm_pkg.sv
// Shared types and helpers for the sign-magnitude adder pipeline.
// Words are sign bit [W-1] over magnitude [W-2:0].
package sm_pkg;

  localparam int SM_WIDTH = 16;
  localparam int SM_FRAC  = 8;
  localparam int SIGN_BIT = SM_WIDTH - 1;
  localparam int MAG_MSB  = SM_WIDTH - 2;

  // Widest word the helpers below accept.
  localparam int SM_MAX_W = 64;

  typedef logic [SM_WIDTH-1:0] sm_word_t;
  typedef logic [SM_MAX_W-2:0] sm_mag_t;

  // Magnitudes narrower than SM_MAX_W-1 are zero-extended by the caller.
  function automatic logic sm_is_zero(input sm_mag_t mag);
    return mag == '0;
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational stage-2 datapath: add/sub, -0 clean-up, saturate or wrap.
// Ports: signL/magL larger operand, signS/magS smaller, result word, ovf.
// Macro SM_ADDER_SAT_EN: saturate magnitude on overflow instead of wrapping.
module sm_add_core
  import sm_pkg::*;
#(
  parameter int WIDTH = SM_WIDTH
) (
  input  logic             signL,
  input  logic             signS,
  input  logic [WIDTH-2:0] magL,
  input  logic [WIDTH-2:0] magS,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int MW = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [MW-1:0]    diff;
  logic [MW-1:0]    mag;
  logic             sign;

  // magL >= magS is guaranteed upstream, so diff never borrows.
  assign sum  = {1'b0, magL} + {1'b0, magS};
  assign diff = magL - magS;

  always_comb begin
    mag  = '0;
    sign = signL;
    ovf  = 1'b0;
    if (signL == signS) begin
      mag = sum[MW-1:0];
      ovf = sum[MW];
`ifdef SM_ADDER_SAT_EN
      if (sum[MW]) begin
        mag = '1;
      end
`endif
    end else begin
      mag = diff;
    end
    // Never emit -0, including a wrapped-to-zero sum.
    if (sm_is_zero((SM_MAX_W-1)'(mag))) begin
      sign = 1'b0;
    end
    result = {sign, mag};
  end

endmodule

// File: rtl/sm_adder_pipe.sv
// Two-stage pipelined sign-magnitude adder with valid/ready on both sides.
// Ports: clk, rst (sync, high), in_valid/in_ready/in_a/in_b,
//   out_valid/out_ready/out_result/out_ovf. Macro: SM_ADDER_SAT_EN.
module sm_adder_pipe
  import sm_pkg::*;
#(
  parameter int WIDTH = SM_WIDTH,
  parameter int FRAC  = SM_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf
);

  localparam int MW = WIDTH - 1;

  if (WIDTH < 4 || WIDTH > SM_MAX_W ||
      FRAC < 0 || FRAC > WIDTH - 1) begin : gBadCfg
    $error("sm_adder_pipe: bad WIDTH/FRAC");
  end

  typedef struct packed {
    logic          signL;
    logic          signS;
    logic [MW-1:0] magL;
    logic [MW-1:0] magS;
  } cmp_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             ovf;
  } sum_t;

  logic s1Valid;
  logic s2Valid;
  logic s2En;
  cmp_t s1D;
  cmp_t s1Q;
  sum_t s2D;
  sum_t s2Q;

  logic [MW-1:0] aMag;
  logic [MW-1:0] bMag;
  logic          aSign;
  logic          bSign;

  assign s2En     = !s2Valid || out_ready;
  assign in_ready = !rst && (!s1Valid || s2En);

  // Stage 1: fold -0 to +0 and order operands by magnitude.
  assign aMag  = in_a[MW-1:0];
  assign bMag  = in_b[MW-1:0];
  assign aSign = in_a[MW] && !sm_is_zero((SM_MAX_W-1)'(aMag));
  assign bSign = in_b[MW] && !sm_is_zero((SM_MAX_W-1)'(bMag));

  always_comb begin
    s1D = '0;
    if (aMag >= bMag) begin
      s1D.signL = aSign;
      s1D.magL  = aMag;
      s1D.signS = bSign;
      s1D.magS  = bMag;
    end else begin
      s1D.signL = bSign;
      s1D.magL  = bMag;
      s1D.signS = aSign;
      s1D.magS  = aMag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Q     <= '0;
    end else if (in_ready) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        s1Q <= s1D;
      end
    end
  end

  // Stage 2: add/sub of the registered compare result.
  sm_add_core #(
    .WIDTH(WIDTH)
  ) uCore (
    .signL (s1Q.signL),
    .signS (s1Q.signS),
    .magL  (s1Q.magL),
    .magS  (s1Q.magS),
    .result(s2D.result),
    .ovf   (s2D.ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid <= 1'b0;
      s2Q     <= '0;
    end else if (s2En) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Q <= s2D;
      end
    end
  end

  assign out_valid  = s2Valid;
  assign out_result = s2Q.result;
  assign out_ovf    = s2Q.ovf;

endmodule

// File: tb/tb_sm_adder_pipe.sv
// Randomised scoreboard bench for sm_adder_pipe.
// Reference sums are computed with signed integer arithmetic.
module tb_sm_adder_pipe;
  import sm_pkg::*;

  localparam int W    = SM_WIDTH;
  localparam int MAXM = (1 << MAG_MSB + 1) - 1;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  sm_word_t     in_a;
  sm_word_t     in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_ovf;

  int   nChecks = 0;
  int   nFails  = 0;
  exp_t expQ[$];
  logic holdPrev = 1'b0;
  logic [W-1:0] prevRes;
  logic prevOvf;
  logic sawStall = 1'b0;
  logic randDone;

  always #5 clk = ~clk;

  sm_adder_pipe #(.WIDTH(W), .FRAC(SM_FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int va, vb, s, m, mag;
    va  = int'(a[MAG_MSB:0]);
    vb  = int'(b[MAG_MSB:0]);
    if (a[SIGN_BIT]) va = -va;
    if (b[SIGN_BIT]) vb = -vb;
    s   = va + vb;
    m   = (s < 0) ? -s : s;
    e.ovf = (m > MAXM);
    if (m > MAXM) begin
`ifdef SM_ADDER_SAT_EN
      mag = MAXM;
`else
      mag = m % (MAXM + 1);
`endif
    end else begin
      mag = m;
    end
    e.res = W'(mag);
    e.res[SIGN_BIT] = (s < 0) && (mag != 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        check("unexpectedOut", 32'(out_result), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("result", 32'(out_result), 32'(e.res));
        check("ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
    if (holdPrev) begin
      check("holdValid", 32'(out_valid), 32'd1);
      check("holdResult", 32'(out_result), 32'(prevRes));
      check("holdOvf", 32'(out_ovf), 32'(prevOvf));
    end
    holdPrev = out_valid && !out_ready && !rst;
    prevRes  = out_result;
    prevOvf  = out_ovf;
    if (in_valid && !in_ready && !rst) sawStall = 1'b1;
    if (rst) expQ.delete();
    if (in_valid && in_ready) expQ.push_back(model(in_a, in_b));
  end

  task automatic sendPair(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          output int waited);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check("acceptTimeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] randWord();
    logic [W-1:0] v;
    v = W'($urandom);
    case ($urandom_range(0, 7))
      0: v[MAG_MSB:0] = '1;
      1: v[MAG_MSB:0] = '0;
      2: v[MAG_MSB-1:0] = '0;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cnt;
    logic [W-1:0] vecA[6];
    logic [W-1:0] vecB[6];
    vecA = '{16'h0180, 16'h0180, 16'h8180, 16'h0340, 16'h8000, 16'h7FFF};
    vecB = '{16'h0340, 16'h8340, 16'h0340, 16'h8340, 16'h8000, 16'h0001};

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'h1234;
    in_b      = 16'h0101;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstValid", 32'(out_valid), 32'd0);
    check("rstResult", 32'(out_result), 32'd0);
    check("rstOvf", 32'(out_ovf), 32'd0);
    check("rstInReady", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;

    // Latency of a single transfer.
    sendPair(16'h0180, 16'h0340, w);
    in_valid = 1'b0;
    check("firstWait", 32'(w), 32'd0);
    @(negedge clk);
    check("lat1Valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat2Valid", 32'(out_valid), 32'd1);
    check("lat2Result", 32'(out_result), 32'h04C0);
    check("lat2Ovf", 32'(out_ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Directed vectors back-to-back: no stalls at full rate.
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      sendPair(vecA[i], vecB[i], w);
      cnt += w;
    end
    sendPair(16'hC000, 16'hC000, w);
    cnt += w;
    in_valid = 1'b0;
    check("b2bWaits", 32'(cnt), 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Output stall mid-stream.
    sawStall = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) sendPair(randWord(), randWord(), w);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("stallSeen", 32'(sawStall), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("stallDrain", 32'(expQ.size()), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    sendPair(16'h0101, 16'h0202, w);
    sendPair(16'h0303, 16'h0404, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("fullValid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flushValid", 32'(out_valid), 32'd0);
    check("flushResult", 32'(out_result), 32'd0);
    @(posedge clk);
    #1;
    sendPair(16'h8180, 16'h0340, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("postRst1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("postRst2", 32'(out_valid), 32'd1);
    check("postRstRes", 32'(out_result), 32'h01C0);
    @(posedge clk);
    #1;

    // Random traffic with random backpressure.
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
          sendPair(randWord(), randWord(), w);
        end
        in_valid = 1'b0;
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    cnt = 0;
    while (expQ.size() != 0 && cnt < 50) begin
      @(posedge clk);
      cnt++;
    end
    check("finalDrain", 32'(expQ.size()), 32'd0);
    @(negedge clk);
    check("finalIdle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
